// File: rtl/ram_burst_master.sv
// Burst master for a synchronous single-port RAM: write bursts go straight to the
// pins; read bursts return through a credit-limited 4-entry FIFO.
module ram_burst_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done
);
  localparam int         FIFO_DEPTH = 4;
  localparam logic [2:0] CREDITS    = 3'd4;

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [4:0]            beats;
  logic                  done_q;

  // vld_pipe[0]: read on the pins this cycle; vld_pipe[1]: ram_rdata valid now
  logic [1:0]            vld_pipe;
  logic [2:0]            credit;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [1:0]            fifo_head, fifo_tail;
  logic [2:0]            fifo_cnt;

  logic issue, push, pop, last_pop;

  assign rd_valid = (fifo_cnt != 3'd0);
  assign rd_data  = fifo_mem[fifo_head];
  assign pop      = rd_valid & rd_ready;
  assign push     = vld_pipe[1];
  assign issue    = (state == RD) && (beats != 5'd0) && (credit < CREDITS);
  // Credit of one while popping means the FIFO holds the final beat and nothing is in flight
  assign last_pop = (state == DRAIN) && pop && (credit == 3'd1);
  assign done     = done_q | last_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      wr_ready  <= 1'b0;
      done_q    <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      addr      <= '0;
      beats     <= '0;
    end else begin
      done_q <= 1'b0;
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
      ram_oe <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            addr      <= cmd_addr;
            beats     <= 5'(cmd_len) + 5'd1;
            if (cmd_write) begin
              state    <= WR;
              wr_ready <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        WR: begin
          if (wr_valid && wr_ready) begin
            ram_cs    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= addr;
            ram_wdata <= wr_data;
            addr      <= addr + ADDR_WIDTH'(1);
            beats     <= beats - 5'd1;
            if (beats == 5'd1) begin
              state     <= IDLE;
              wr_ready  <= 1'b0;
              busy      <= 1'b0;
              done_q    <= 1'b1;
              cmd_ready <= 1'b1;
            end
          end
        end
        RD: begin
          if (issue) begin
            ram_cs   <= 1'b1;
            ram_oe   <= 1'b1;
            ram_addr <= addr;
            addr     <= addr + ADDR_WIDTH'(1);
            beats    <= beats - 5'd1;
            if (beats == 5'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      credit    <= '0;
      fifo_head <= '0;
      fifo_tail <= '0;
      fifo_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      credit   <= credit + 3'(issue) - 3'(pop);
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
      if (push) begin
        fifo_mem[fifo_tail] <= ram_rdata;
        fifo_tail           <= fifo_tail + 2'd1;
      end
      if (pop) fifo_head <= fifo_head + 2'd1;
    end
  end

  // Credit limiting keeps the FIFO from ever being pushed while full
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (fifo_cnt == 3'(FIFO_DEPTH))));
      assert (!(ram_we && ram_oe));
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: directed bursts plus randomized bursts scored
// against a word-level memory model and pin/handshake monitors.
module tb_ram_burst_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_data;
  logic        ram_cs, ram_we, ram_oe;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        busy, done;

  ram_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t  wq[$];
  ev_t  rcs_q[$];
  ev_t  rq[$];
  int   dq[$];
  int   cs_n, iss_n, pop_n;

  logic [15:0] ram_mem [65536];
  logic [15:0] ref_mem [int];
  logic [15:0] wdat [16];
  int          exp_cyc [16];

  // RAM: read data valid for the cycle after the sampling edge
  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= (ram_cs && !ram_we) ? ram_mem[ram_addr] : 16'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) dq.push_back(cyc);
    if (rst) begin
      iss_n = 0;
      pop_n = 0;
    end else begin
      if (ram_cs) cs_n++;
      if (ram_cs && ram_we) wq.push_back('{ram_addr, ram_wdata, cyc});
      if (ram_cs && !ram_we) begin
        iss_n++;
        rcs_q.push_back('{ram_addr, 16'h0, cyc});
      end
      chk("pins_legal", 32'(ram_cs ? !(ram_we && ram_oe) : !(ram_we || ram_oe)), 32'd1);
      chk("credit_le_4", 32'((iss_n - pop_n) <= 4), 32'd1);
      if (rd_valid && rd_ready) begin
        pop_n++;
        rq.push_back('{16'h0, rd_data, cyc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wq.delete(); rcs_q.delete(); rq.delete(); dq.delete();
    cs_n = 0;
  endtask

  task automatic chk_rst_outs();
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_done",      32'(done), 0);
    chk("rst_wr_ready",  32'(wr_ready), 0);
    chk("rst_rd_valid",  32'(rd_valid), 0);
    chk("rst_ram_cs",    32'(ram_cs), 0);
    chk("rst_ram_we",    32'(ram_we), 0);
    chk("rst_ram_oe",    32'(ram_oe), 0);
    chk("rst_ram_addr",  32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_rd_data",   32'(rd_data), 0);
  endtask

  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [3:0] l);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int t = 0; t < 50 && !cmd_ready; t++) step();
    chk("cmd_ready_seen", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 16'($urandom); cmd_len = 4'($urandom);
    chk("busy_after_accept", 32'(busy), 1);
    chk("cmd_ready_low_busy", 32'(cmd_ready), 0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [3:0] l, input int gap_mode);
    clear();
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (gap_mode == 1 && (i % 2 == 1)) begin
        wr_valid = 1'b0; wr_data = 16'($urandom); step(); step();
      end
      if (gap_mode == 2)
        for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
          wr_valid = 1'b0; wr_data = 16'($urandom); step();
        end
      wr_valid = 1'b1; wr_data = wdat[i];
      for (int t = 0; t < 50 && !wr_ready; t++) step();
      exp_cyc[i] = cyc + 1;
      step();
    end
    wr_valid = 1'b0;
    step();
    chk("wr_count", wq.size(), int'(l) + 1);
    chk("wr_cs_cycles", cs_n, int'(l) + 1);
    for (int i = 0; i <= int'(l) && i < wq.size(); i++) begin
      chk("wr_addr", 32'(wq[i].addr), 32'(16'(a + 16'(i))));
      chk("wr_data", 32'(wq[i].data), 32'(wdat[i]));
      chk("wr_cycle", wq[i].cyc, exp_cyc[i]);
      ref_mem[int'(16'(a + 16'(i)))] = wdat[i];
    end
    chk("wr_done_n", dq.size(), 1);
    if (dq.size() > 0) chk("wr_done_cycle", dq[0], exp_cyc[l]);
  endtask

  // mode 0: rd_ready=1; 1: stalled 10 cycles then 1; 2: random
  task automatic do_read(input logic [15:0] a, input logic [3:0] l, input int mode);
    int  stall_end;
    int  n;
    bit  fin;
    logic [15:0] ad;
    clear();
    stall_end = 0;
    fin = 1'b0;
    send_cmd(1'b0, a, l);
    for (int j = 0; j < 300 && !fin; j++) begin
      wr_valid = 1'b1; wr_data = 16'($urandom);
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (j >= 10);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      if (mode == 1 && j == 10) stall_end = cyc;
      #1;
      if (done) fin = 1'b1;
      step();
    end
    rd_ready = 1'b0; wr_valid = 1'b0;
    chk("rd_done_seen", 32'(fin), 1);
    chk("rd_count", rq.size(), int'(l) + 1);
    chk("rd_issue_count", rcs_q.size(), int'(l) + 1);
    chk("rd_cs_cycles", cs_n, int'(l) + 1);
    chk("rd_no_writes", wq.size(), 0);
    for (int i = 0; i <= int'(l); i++) begin
      ad = 16'(a + 16'(i));
      if (i < rcs_q.size()) chk("rd_issue_addr", 32'(rcs_q[i].addr), 32'(ad));
      if (i < rq.size() && ref_mem.exists(int'(ad)))
        chk("rd_data", 32'(rq[i].data), 32'(ref_mem[int'(ad)]));
      if (mode == 0 && i < rq.size() && rcs_q.size() > 0)
        chk("rd_cycle", rq[i].cyc, rcs_q[0].cyc + 2 + i);
    end
    chk("rd_done_n", dq.size(), 1);
    if (dq.size() > 0 && rq.size() > 0) chk("rd_done_cycle", dq[0], rq[rq.size()-1].cyc);
    if (mode == 1 && l >= 4) begin
      n = 0;
      foreach (rcs_q[i]) if (rcs_q[i].cyc <= stall_end) n++;
      chk("rd_stall_issues", n, 4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pops;
    logic [15:0] last_a;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    cs_n = 0;
    repeat (3) step();
    chk_rst_outs();
    rst = 1'b0;
    chk("cmd_ready_before_edge", 32'(cmd_ready), 0);
    step();
    chk("cmd_ready_after_edge", 32'(cmd_ready), 1);

    // Write then read back 0x10..0x13
    for (int i = 0; i < 4; i++) wdat[i] = 16'(16'hA0 + i);
    do_write(16'h0010, 4'd3, 0);
    do_read(16'h0010, 4'd3, 0);
    for (int i = 0; i < 4 && i < rq.size(); i++) chk("rd_const", 32'(rq[i].data), 32'(16'hA0 + i));

    // 16-beat backpressured read
    for (int i = 0; i < 16; i++) wdat[i] = 16'($urandom);
    do_write(16'h0100, 4'd15, 0);
    do_read(16'h0100, 4'd15, 1);

    // Address wrap
    for (int i = 0; i < 4; i++) wdat[i] = 16'(16'hB0 + i);
    do_write(16'hFFFE, 4'd3, 0);
    if (wq.size() == 4) chk("wrap_addr2", 32'(wq[2].addr), 32'h0);
    do_read(16'hFFFE, 4'd3, 0);

    // Single beat read, then write with gaps
    do_read(16'h0012, 4'd0, 0);
    for (int i = 0; i < 6; i++) wdat[i] = 16'($urandom);
    do_write(16'h0300, 4'd5, 1);

    // Reset in the middle of an 8-beat read
    for (int i = 0; i < 8; i++) wdat[i] = 16'($urandom);
    do_write(16'h0200, 4'd7, 0);
    clear();
    send_cmd(1'b0, 16'h0200, 4'd7);
    pops = 0;
    for (int j = 0; j < 50 && pops < 2; j++) begin
      rd_ready = 1'b1;
      #1;
      if (rd_valid) pops++;
      step();
    end
    chk("rst_test_pops", pops, 2);
    #2 rst = 1'b1;
    #1;
    chk_rst_outs();
    rd_ready = 1'b0;
    repeat (3) step();
    chk("rst_hold_rd_valid", 32'(rd_valid), 0);
    rst = 1'b0;
    chk("cmd_ready_post_rst", 32'(cmd_ready), 0);
    step();
    chk("cmd_ready_post_rst_edge", 32'(cmd_ready), 1);
    chk("no_done_on_reset", dq.size(), 0);
    do_read(16'h0200, 4'd7, 0);

    // Randomized bursts against the memory model
    last_a = 16'h0100;
    for (int k = 0; k < 12; k++) begin
      logic [15:0] a;
      logic [3:0]  l;
      a = ($urandom_range(3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(7))) : 16'($urandom);
      l = 4'($urandom);
      if (k % 2 == 0) begin
        for (int i = 0; i < 16; i++) wdat[i] = 16'($urandom);
        do_write(a, l, 2);
        last_a = a;
      end else begin
        do_read(16'(last_a + 16'($urandom_range(3))), l, 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16: RAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16: RAM word width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports are as follows.
- clk  in  1: sole clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
REQ-004 The command port SHALL be as follows.
- cmd_valid  in  1: command offered.
- cmd_ready  out  1: command accepted when both high.
- cmd_write  in  1: 1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH: start address.
- cmd_len  in  4: beats minus 1 (1..16 beats).
REQ-005 The write-data port SHALL be as follows.
- wr_valid  in  1: write beat offered.
- wr_ready  out  1: write beat accepted when both high.
- wr_data  in  DATA_WIDTH: write beat data.
REQ-006 The read-data port SHALL be as follows.
- rd_valid  out  1: read beat offered.
- rd_ready  in  1: read beat accepted when both high.
- rd_data  out  DATA_WIDTH: read beat data.
REQ-007 The RAM side SHALL be as follows; all outputs are registered.
- ram_cs  out  1: chip select.
- ram_we  out  1: write enable.
- ram_oe  out  1: output enable.
- ram_addr  out  ADDR_WIDTH: word address.
- ram_wdata  out  DATA_WIDTH: write data.
- ram_rdata  in  DATA_WIDTH: read data, valid exactly 1 cycle after a clock edge sampling ram_cs=1, ram_we=0.
REQ-008 The status port SHALL be as follows.
- busy  out  1: burst in progress.
- done  out  1: one-cycle completion pulse.

Function
REQ-009 The FSM SHALL have the states IDLE, WR, RD and DRAIN.
REQ-010 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state other than IDLE.
REQ-011 On command accept, the block SHALL latch address and beat count (cmd_len+1), then go to WR if cmd_write=1, else RD.
REQ-012 In WR, wr_ready SHALL be 1 while beats remain; each accepted beat SHALL drive ram_cs=1, ram_we=1, ram_oe=0, ram_addr=current address, ram_wdata=wr_data in the following cycle.
REQ-013 In WR, cycles with no accepted beat SHALL drive ram_cs=0 next cycle; write throughput is 1 beat/cycle.
REQ-014 After the last write beat is driven on the RAM pins, done SHALL pulse in that same cycle and the FSM SHALL enter IDLE.
REQ-015 In RD, the block SHALL issue one read per cycle (ram_cs=1, ram_we=0, ram_oe=1) while beats remain to issue and credit is available.
- Credit: outstanding reads plus read-FIFO occupancy SHALL never exceed 4.
REQ-016 Returned ram_rdata SHALL be pushed into a 4-entry read FIFO; rd_valid = FIFO not empty; rd_data = FIFO head; pop on rd_valid & rd_ready.
REQ-017 A simultaneous FIFO push and pop SHALL leave occupancy unchanged and preserve order.
REQ-018 A full FIFO SHALL be unreachable by construction; a push when full is a design error flagged by an assertion.
REQ-019 After all reads are issued, the FSM SHALL go to DRAIN.
REQ-020 In DRAIN, done SHALL pulse in the cycle the last beat is popped, and the FSM SHALL return to IDLE.
REQ-021 With rd_ready held at 1, read throughput SHALL be 1 beat/cycle after 2-cycle initial latency: issue decision, pin cycle, then FIFO valid.
REQ-022 The address SHALL increment by 1 per beat, modulo 2^ADDR_WIDTH; the address after all-ones is 0.
REQ-023 The beat counter SHALL be 5 bits; cmd_len=15 SHALL yield exactly 16 beats, cmd_len=0 exactly 1 beat.
REQ-024 ram_cs=0 SHALL imply ram_we=0 and ram_oe=0; ram_we and ram_oe SHALL never both be 1.
REQ-025 Inputs on wr_* outside WR, and rd_ready while rd_valid=0, SHALL be ignored.

Reset
REQ-026 While rst=1, the block SHALL immediately force the following, independent of clk.
- FSM = IDLE.
- cmd_ready = 0, busy = 0, done = 0, wr_ready = 0, rd_valid = 0.
- ram_cs = 0, ram_we = 0, ram_oe = 0.
- ram_addr = 0, ram_wdata = 0, rd_data = 0.
- Read FIFO emptied; credit and beat counters = 0.
REQ-027 cmd_ready SHALL rise on the first clock edge after rst deasserts.
REQ-028 Reset mid-burst SHALL abandon the burst; in-flight RAM read data SHALL be discarded and no done pulse SHALL occur.

Verification
REQ-029 The bench SHALL cover the following directed scenarios.
- Write burst: cmd_addr=0x0010, cmd_len=3, wr_data 0xA0..0xA3 back-to-back -> RAM writes 0x10..0x13 on consecutive cycles; done pulses with the 4th write.
- Read burst, rd_ready=1: RAM model preloaded, cmd_addr=0x0010, cmd_len=3 -> rd_data 0xA0..0xA3 on 4 consecutive cycles starting 2 cycles after issue start; done pulses on the last pop.
- Backpressure: 16-beat read with rd_ready=0 for 10 cycles -> at most 4 reads outstanding+buffered, ram_cs=0 while stalled; no data lost or reordered.
- Wrap: cmd_addr=0xFFFE, cmd_len=3, write -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Single beat and write stall: cmd_len=0 read -> exactly 1 ram_cs cycle, 1 rd beat; write with wr_valid gaps -> ram_cs=0 in gap cycles.
- Reset mid-read: rst asserted after beat 2 of 8 -> all outputs at reset values immediately; no done pulse; next command executes normally.
